// File: rtl/cpu32_ctl_pkg.sv
// cpu32_ctl_pkg: shared state encodings, opcode map and fault codes for the cpu32 control sequencer.
package cpu32_ctl_pkg;
   typedef logic [2:0] state_t;
   localparam state_t S_FETCH  = 3'd0;
   localparam state_t S_DECODE = 3'd1;
   localparam state_t S_EXEC   = 3'd2;
   localparam state_t S_MEM    = 3'd3;
   localparam state_t S_WB     = 3'd4;
   localparam state_t S_FAULT  = 3'd5;
   localparam int OP_ALUR = 0;
   localparam int OP_ALUI = 1;
   localparam int OP_LD   = 2;
   localparam int OP_ST   = 3;
   localparam int OP_BR   = 4;
   localparam int OP_BRI  = 5;
   localparam int OP_NUM  = 6;
   localparam logic [1:0] FC_NONE    = 2'd0;
   localparam logic [1:0] FC_ILLEGAL = 2'd1;
   localparam logic [1:0] FC_TMO     = 2'd2;
   localparam logic [3:0] ALU_ADD = 4'b0010;
endpackage

// File: rtl/ctl_decode.sv
// ctl_decode: combinational state+IR+cond to control word decode.
// Purely registered inputs keep every control output free of input-to-output paths.
module ctl_decode
   import cpu32_ctl_pkg::*;
#(
   parameter int OPW      = 4,
   parameter int FUNCW    = 4,
   parameter int ALUW     = 4,
   parameter int LINK_BIT = 3
) (
   input  logic [2:0]       state_i,
   input  logic [OPW-1:0]   op_i,
   input  logic [FUNCW-1:0] func_i,
   input  logic             cond_i,
   output logic             ifetch_req_o,
   output logic             ram_req_o,
   output logic             ram_rd_o,
   output logic             ram_we_o,
   output logic             regs_we_o,
   output logic             pc_we_o,
   output logic             branch_o,
   output logic             branch_ind_o,
   output logic             d_or_b_o,
   output logic             imm16_o,
   output logic [ALUW-1:0]  alu_func_o
);
   logic is_ld, is_st, is_br, is_bri, act, mem, wb;
   assign is_ld  = op_i == OPW'(OP_LD);
   assign is_st  = op_i == OPW'(OP_ST);
   assign is_br  = op_i == OPW'(OP_BR);
   assign is_bri = op_i == OPW'(OP_BRI);
   assign act    = state_i inside {S_DECODE, S_EXEC, S_MEM, S_WB};
   assign mem    = state_i == S_MEM;
   assign wb     = state_i == S_WB;
   assign ifetch_req_o = state_i == S_FETCH;
   assign ram_req_o    = mem;
   assign ram_rd_o     = mem & is_ld;
   assign ram_we_o     = mem & is_st;
   assign pc_we_o      = wb;
   // Branches write the link register only when taken and the link bit is set.
   assign regs_we_o    = wb & ((op_i <= OPW'(OP_LD)) | ((is_br | is_bri) & cond_i & func_i[LINK_BIT]));
   assign branch_o     = wb & is_br & cond_i;
   assign branch_ind_o = wb & is_bri & cond_i;
   assign d_or_b_o     = act & (op_i == OPW'(OP_ALUI) | is_ld | is_br);
   assign imm16_o      = act & (op_i != '0);
   assign alu_func_o   = !act ? '0 : (is_ld | is_st) ? ALUW'(ALU_ADD) : ALUW'(func_i);
endmodule

// File: rtl/control_seq.sv
// control_seq: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for cpu32 with
// instruction register, branch condition latch, RAM timeout and illegal-opcode fault trap.
module control_seq
   import cpu32_ctl_pkg::*;
#(
   parameter int OPW      = 4,
   parameter int FUNCW    = 4,
   parameter int ALUW     = 4,
   parameter int LINK_BIT = 3,
   parameter int MEM_TMO  = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ifetch_ack,
   input  logic [OPW-1:0]   ins_opcode,
   input  logic [FUNCW-1:0] ins_opfunc,
   input  logic             adata_zero,
   input  logic             ram_ack,
   output logic             ifetch_req,
   output logic             ram_req,
   output logic             ram_rd,
   output logic             ram_we,
   output logic             regs_we,
   output logic             pc_we,
   output logic             branch,
   output logic             branch_ind,
   output logic             d_or_b,
   output logic             imm16,
   output logic [ALUW-1:0]  alu_func,
   output logic             fault,
   output logic [1:0]       fault_code
);
   state_t           state_q, state_d;
   logic [OPW-1:0]   op_q, op_d;
   logic [FUNCW-1:0] func_q, func_d;
   logic             cond_q, cond_d;
   logic [7:0]       tmo_q, tmo_d, tmo_inc;
   logic             fault_q, fault_d;
   logic [1:0]       code_q, code_d;
   assign tmo_inc = tmo_q + 8'd1;
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      func_d  = func_q;
      cond_d  = cond_q;
      tmo_d   = tmo_q;
      fault_d = fault_q;
      code_d  = code_q;
      case (state_q)
         S_FETCH: if (ifetch_ack) begin
            op_d    = ins_opcode;
            func_d  = ins_opfunc;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            cond_d  = (func_q[0] & adata_zero) | (func_q[1] & ~adata_zero);
            fault_d = op_q >= OPW'(OP_NUM);
            code_d  = fault_d ? FC_ILLEGAL : FC_NONE;
            state_d = fault_d ? S_FAULT : S_EXEC;
         end
         S_EXEC: state_d = (op_q == OPW'(OP_LD) || op_q == OPW'(OP_ST)) ? S_MEM : S_WB;
         // An ack on the final allowed cycle still completes the access.
         S_MEM: begin
            tmo_d   = ram_ack ? 8'd0 : tmo_inc;
            fault_d = !ram_ack && tmo_inc == 8'(MEM_TMO);
            code_d  = fault_d ? FC_TMO : code_q;
            state_d = ram_ack ? S_WB : fault_d ? S_FAULT : S_MEM;
         end
         S_WB: state_d = S_FETCH;
         default: state_d = S_FAULT;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         op_q    <= '0;
         func_q  <= '0;
         cond_q  <= 1'b0;
         tmo_q   <= '0;
         fault_q <= 1'b0;
         code_q  <= FC_NONE;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         func_q  <= func_d;
         cond_q  <= cond_d;
         tmo_q   <= tmo_d;
         fault_q <= fault_d;
         code_q  <= code_d;
      end
   end
   assign fault      = fault_q;
   assign fault_code = code_q;
   ctl_decode #(.OPW(OPW), .FUNCW(FUNCW), .ALUW(ALUW), .LINK_BIT(LINK_BIT)) u_dec (
      .state_i      (state_q),
      .op_i         (op_q),
      .func_i       (func_q),
      .cond_i       (cond_q),
      .ifetch_req_o (ifetch_req),
      .ram_req_o    (ram_req),
      .ram_rd_o     (ram_rd),
      .ram_we_o     (ram_we),
      .regs_we_o    (regs_we),
      .pc_we_o      (pc_we),
      .branch_o     (branch),
      .branch_ind_o (branch_ind),
      .d_or_b_o     (d_or_b),
      .imm16_o      (imm16),
      .alu_func_o   (alu_func)
   );
endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: scoreboard bench; stimulus queues expected strobe events, a negedge monitor checks them.
module tb_control_seq;
   localparam int MEM_TMO = 15;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ifetch_ack = 1'b0, adata_zero = 1'b0, ram_ack = 1'b0;
   logic [3:0] ins_opcode = '0, ins_opfunc = '0;
   logic ifetch_req, ram_req, ram_rd, ram_we, regs_we, pc_we, branch, branch_ind, d_or_b, imm16, fault;
   logic [3:0] alu_func;
   logic [1:0] fault_code;
   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   logic fault_prev = 1'b0;
   typedef struct { string name; int cyc; logic [16:0] vec; } exp_t;
   exp_t sbq[$];
   exp_t e;
   logic [16:0] obs;

   control_seq #(.OPW(4), .FUNCW(4), .ALUW(4), .LINK_BIT(3), .MEM_TMO(MEM_TMO)) dut (
      .clk(clk), .rst_n(rst_n), .ifetch_ack(ifetch_ack), .ins_opcode(ins_opcode),
      .ins_opfunc(ins_opfunc), .adata_zero(adata_zero), .ram_ack(ram_ack),
      .ifetch_req(ifetch_req), .ram_req(ram_req), .ram_rd(ram_rd), .ram_we(ram_we),
      .regs_we(regs_we), .pc_we(pc_we), .branch(branch), .branch_ind(branch_ind),
      .d_or_b(d_or_b), .imm16(imm16), .alu_func(alu_func), .fault(fault), .fault_code(fault_code)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [16:0] pk(input logic ifr, rq, rd, we, rwe, pw, br, bi, db, im,
                                      input logic [3:0] alu, input logic fl, input logic [1:0] fc);
      return {ifr, rq, rd, we, rwe, pw, br, bi, db, im, alu, fl, fc};
   endfunction

   function automatic logic [16:0] outs();
      return pk(ifetch_req, ram_req, ram_rd, ram_we, regs_we, pc_we, branch, branch_ind,
                d_or_b, imm16, alu_func, fault, fault_code);
   endfunction

   task automatic push(input string n, input int c, input logic [16:0] v);
      exp_t x;
      x.name = n; x.cyc = c; x.vec = v;
      sbq.push_back(x);
   endtask

   task automatic chk(input string n, input logic [16:0] act, input logic [16:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: outputs %b, wanted %b", n, act, exp);
      end
   endtask

   always @(negedge clk) begin
      obs = outs();
      if (pc_we | ram_req | regs_we | branch | branch_ind | (fault & ~fault_prev)) begin
         n_cmp++;
         if (sbq.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: outputs %b at cycle %0d, wanted no event", obs, cyc);
         end else begin
            e = sbq.pop_front();
            if (obs !== e.vec || cyc != e.cyc) begin
               n_bad++;
               $display("FAIL %s: outputs %b at cycle %0d, wanted %b at cycle %0d", e.name, obs, cyc, e.vec, e.cyc);
            end
         end
      end
      fault_prev = fault;
   end

   // waits: RAM wait cycles before ack (mem ops); negative means ack never comes.
   task automatic issue(input string nm, input logic [3:0] op, input logic [3:0] f, input logic az,
                        input int waits, input logic rd, we, rwe, br, bi, db, im, input logic [3:0] alu);
      int c0, last;
      logic mem;
      mem = rd | we;
      @(negedge clk);
      c0 = cyc;
      ifetch_ack = 1'b1; ins_opcode = op; ins_opfunc = f; adata_zero = ~az;
      if (op >= 4'd6) begin
         push({nm, "_fault"}, c0 + 2, pk(0,0,0,0,0,0,0,0,0,0,4'h0,1,2'd1));
         last = c0 + 8;
      end else if (!mem) begin
         push({nm, "_wb"}, c0 + 3, pk(0,0,0,0,rwe,1,br,bi,db,im,alu,0,2'd0));
         last = c0 + 3;
      end else if (waits >= 0) begin
         for (int j = 0; j <= waits; j++)
            push({nm, "_mem"}, c0 + 3 + j, pk(0,1,rd,we,0,0,0,0,db,im,alu,0,2'd0));
         push({nm, "_wb"}, c0 + 4 + waits, pk(0,0,0,0,rwe,1,br,bi,db,im,alu,0,2'd0));
         last = c0 + 4 + waits;
      end else begin
         for (int j = 0; j < MEM_TMO; j++)
            push({nm, "_mem"}, c0 + 3 + j, pk(0,1,rd,we,0,0,0,0,db,im,alu,0,2'd0));
         push({nm, "_tmo"}, c0 + 3 + MEM_TMO, pk(0,0,0,0,0,0,0,0,0,0,4'h0,1,2'd2));
         last = c0 + 6 + MEM_TMO;
      end
      while (cyc < last) begin
         @(negedge clk);
         ifetch_ack = (op >= 4'd6) && cyc > c0 + 2;
         ins_opcode = 4'($urandom);
         ins_opfunc = 4'($urandom);
         adata_zero = (cyc == c0 + 1) ? az : ~az;
         ram_ack = (mem && waits >= 0 && cyc == c0 + 3 + waits) || (op >= 4'd6 && cyc > c0 + 2);
      end
      ifetch_ack = 1'b0;
      ram_ack = 1'b0;
   endtask

   task automatic do_reset(input string nm);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk(nm, outs(), pk(1,0,0,0,0,0,0,0,0,0,4'h0,0,2'd0));
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int c0;
      #1 chk("reset_initial", outs(), pk(1,0,0,0,0,0,0,0,0,0,4'h0,0,2'd0));
      @(negedge clk);
      rst_n = 1'b1;
      issue("alu_reg", 4'd0, 4'd5,  1'b0, 0,  0,0,1,0,0,0,0, 4'd5);
      issue("st_w3",   4'd3, 4'd0,  1'b0, 3,  0,1,0,0,0,0,1, 4'd2);
      issue("br_taken",4'd4, 4'd9,  1'b1, 0,  0,0,1,1,0,1,1, 4'd9);
      issue("br_not",  4'd4, 4'd9,  1'b0, 0,  0,0,0,0,0,1,1, 4'd9);
      issue("ld_w0",   4'd2, 4'd3,  1'b0, 0,  1,0,1,0,0,1,1, 4'd2);
      issue("alu_imm", 4'd1, 4'hA,  1'b1, 0,  0,0,1,0,0,1,1, 4'hA);
      issue("bri_unc", 4'd5, 4'd3,  1'b0, 0,  0,0,0,0,1,0,1, 4'd3);
      issue("br_nop",  4'd4, 4'd8,  1'b1, 0,  0,0,0,0,0,1,1, 4'd8);
      issue("bri_link",4'd5, 4'hE,  1'b0, 0,  0,0,1,0,1,0,1, 4'hE);
      issue("st_w14",  4'd3, 4'd1,  1'b0, MEM_TMO - 1, 0,1,0,0,0,0,1, 4'd2);
      issue("ld_tmo",  4'd2, 4'd0,  1'b0, -1, 1,0,1,0,0,1,1, 4'd2);
      chk("tmo_held", outs(), pk(0,0,0,0,0,0,0,0,0,0,4'h0,1,2'd2));
      do_reset("reset_after_tmo");
      @(negedge clk);
      c0 = cyc;
      ifetch_ack = 1'b1; ins_opcode = 4'd2; ins_opfunc = 4'd0;
      push("ld_rst_mem", c0 + 3, pk(0,1,1,0,0,0,0,0,1,1,4'd2,0,2'd0));
      @(negedge clk);
      ifetch_ack = 1'b0;
      @(negedge clk);
      do_reset("reset_mid_mem");
      repeat (3) @(negedge clk);
      chk("no_retry", outs(), pk(1,0,0,0,0,0,0,0,0,0,4'h0,0,2'd0));
      issue("illegal", 4'd7, 4'd5,  1'b0, 0,  0,0,0,0,0,0,0, 4'd0);
      chk("illegal_held", outs(), pk(0,0,0,0,0,0,0,0,0,0,4'h0,1,2'd1));
      do_reset("reset_after_illegal");
      issue("alu_after", 4'd0, 4'd7, 1'b0, 0, 0,0,1,0,0,0,0, 4'd7);
      repeat (2) @(negedge clk);
      n_cmp++;
      if (sbq.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: %0d events pending, wanted 0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
